mem_arbiter: RTL and testbench

Multi-cycle controller that shares the single main-memory port between the instruction-cache and data-cache controllers. It services I-cache block fills, D-cache block fills and D-side write-through stores. Each fill issues one word request per cycle to a pipelined memory and streams the returned words back to the requesting cache. It sits between the two cache controllers and the main memory, replacing the separate single-cycle instruction and data memories in the pipelined core.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter -- shares one pipelined memory port between I/D block fills
//                and D-side write-through stores.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_miss,
   input  logic [15:0]                    i_miss_addr,
   input  logic                           d_miss,
   input  logic [15:0]                    d_miss_addr,
   input  logic                           d_wr_req,
   input  logic [15:0]                    d_wr_addr,
   input  logic [15:0]                    d_wr_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [15:0]                    mem_addr,
   output logic [15:0]                    mem_data_in,
   input  logic [15:0]                    mem_data_out,
   input  logic                           mem_data_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_fill_done,
   output logic                           d_fill_done,
   output logic                           d_wr_ack,
   output logic                           busy
);

   localparam int              c_CW       = $clog2(BLOCK_WORDS) + 1;
   localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
   localparam logic [c_CW-1:0] c_NWORDS   = c_CW'(BLOCK_WORDS);
   localparam logic [c_CW-1:0] c_LAST     = c_CW'(BLOCK_WORDS - 1);
   localparam logic [15:0]     c_OFF_MASK = 16'(2 * BLOCK_WORDS - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WRITE = 2'd1;
   localparam logic [1:0] c_FILL  = 2'd2;

   logic [1:0]      r_state;
   logic            r_owner_d;
   logic [15:0]     r_base;
   logic [15:0]     r_wr_addr;
   logic [15:0]     r_wr_data;
   logic [c_CW-1:0] r_issue_cnt;
   logic [c_CW-1:0] r_recv_cnt;

   logic w_issuing;
   logic w_rx;
   logic w_last;

   // Issue and receive run independently; only the valid count ends a fill.
   assign w_issuing = (r_state == c_FILL) && (r_issue_cnt < c_NWORDS);
   assign w_rx      = (r_state == c_FILL) && mem_data_valid;
   assign w_last    = w_rx && (r_recv_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_owner_d   <= 1'b0;
         r_base      <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_issue_cnt <= '0;
               r_recv_cnt  <= '0;
               if (d_wr_req) begin
                  r_state   <= c_WRITE;
                  r_wr_addr <= d_wr_addr;
                  r_wr_data <= d_wr_data;
               end else if (d_miss) begin
                  r_state   <= c_FILL;
                  r_owner_d <= 1'b1;
                  r_base    <= d_miss_addr & ~c_OFF_MASK;
               end else if (i_miss) begin
                  r_state   <= c_FILL;
                  r_owner_d <= 1'b0;
                  r_base    <= i_miss_addr & ~c_OFF_MASK;
               end
            end
            c_WRITE: r_state <= c_IDLE;
            c_FILL: begin
               if (w_issuing) r_issue_cnt <= r_issue_cnt + c_ONE;
               if (w_rx)      r_recv_cnt  <= r_recv_cnt + c_ONE;
               if (w_last)    r_state     <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   always_comb begin
      busy        = (r_state != c_IDLE);
      mem_en      = w_issuing || (r_state == c_WRITE);
      mem_wr      = (r_state == c_WRITE);
      mem_addr    = '0;
      mem_data_in = '0;
      d_wr_ack    = (r_state == c_WRITE);
      if (r_state == c_WRITE) begin
         mem_addr    = r_wr_addr;
         mem_data_in = r_wr_data;
      end else if (w_issuing) begin
         mem_addr = r_base + 16'({r_issue_cnt, 1'b0});
      end
      fill_data   = w_rx ? mem_data_out : '0;
      fill_word   = w_rx ? r_recv_cnt[c_CW-2:0] : '0;
      i_fill_we   = w_rx && !r_owner_d;
      d_fill_we   = w_rx && r_owner_d;
      i_fill_done = w_last && !r_owner_d;
      d_fill_done = w_last && r_owner_d;
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter -- scenario table, corner sequences and random traffic for
//                   mem_arbiter, checked cycle by cycle against a txn model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam int BW = 8;
   localparam int WW = $clog2(BW);
   localparam int OW = 59;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_miss, d_miss, d_wr_req;
   logic [15:0]   i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic          mem_en, mem_wr;
   logic [15:0]   mem_addr, mem_data_in, mem_data_out, fill_data;
   logic          mem_data_valid;
   logic [WW-1:0] fill_word;
   logic          i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.BLOCK_WORDS(BW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .d_wr_ack(d_wr_ack), .busy(busy)
   );

   typedef struct {
      logic [15:0] data;
      int          due;
   } mem_rsp_t;
   mem_rsp_t mq[$];

   typedef struct {
      logic        im;  logic [15:0] ia;
      logic        dm;  logic [15:0] da;
      logic        w;   logic [15:0] wa;  logic [15:0] wd;
      int          lat;
      logic [15:0] e_first;
      int          e_i, e_d, e_ack;
   } scn_t;
   scn_t tbl[7];

   int n_vec = 0, n_err = 0;
   int cyc = 0;
   int lat_min = 4, lat_max = 4;

   // transaction-level reference
   bit          m_active = 0, m_is_wr = 0, m_owner_d = 0;
   int          m_start = 0, m_recv = 0;
   logic [15:0] m_base = 0, m_waddr = 0, m_wdata = 0;

   bit          drop_i = 0, drop_d = 0, drop_w = 0;
   int          scn_r = 0, ev_i = -1, ev_d = -1, ev_ack = -1;
   bit          have_first = 0;
   logic [15:0] first_rd = 0, ack_addr = 0, ack_data = 0;

   function automatic logic [15:0] block_base(input logic [15:0] a);
      int sz;
      sz = 2 * BW;
      return 16'((int'(a) / sz) * sz);
   endfunction

   function automatic logic [OW-1:0] pack_out();
      return {busy, mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
              i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack};
   endfunction

   task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: outputs got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got, exp, exp);
      end
   endtask

   task automatic model_cycle(output logic [OW-1:0] exp);
      logic          e_busy, e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_ack;
      logic [15:0]   e_addr, e_din, e_fd;
      logic [WW-1:0] e_fw;
      int            k;
      {e_busy, e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_ack} = '0;
      e_addr = '0; e_din = '0; e_fd = '0; e_fw = '0;
      if (!m_active) begin
         if (d_wr_req) begin
            m_active = 1; m_is_wr = 1; m_start = cyc + 1;
            m_waddr = d_wr_addr; m_wdata = d_wr_data;
         end else if (d_miss || i_miss) begin
            m_active = 1; m_is_wr = 0; m_start = cyc + 1; m_recv = 0;
            m_owner_d = d_miss;
            m_base = block_base(d_miss ? d_miss_addr : i_miss_addr);
         end
      end else begin
         e_busy = 1;
         if (m_is_wr) begin
            e_en = 1; e_wr = 1; e_addr = m_waddr; e_din = m_wdata; e_ack = 1;
            m_active = 0;
         end else begin
            k = cyc - m_start;
            if (k < BW) begin
               e_en = 1;
               e_addr = m_base + 16'(2 * k);
            end
            if (mem_data_valid) begin
               e_fd = mem_data_out;
               e_fw = WW'(m_recv);
               if (m_owner_d) e_dwe = 1; else e_iwe = 1;
               if (m_recv == BW - 1) begin
                  if (m_owner_d) e_ddn = 1; else e_idn = 1;
                  m_active = 0;
               end
               m_recv++;
            end
         end
      end
      exp = {e_busy, e_en, e_wr, e_addr, e_din, e_fd, e_fw, e_iwe, e_dwe, e_idn, e_ddn, e_ack};
   endtask

   // One clock cycle: memory response, compare, record, then advance.
   task automatic step();
      logic [OW-1:0] exp;
      mem_rsp_t      r;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mem_data_valid = 1'b1;
         mem_data_out   = mq[0].data;
         mq.delete(0);
      end else begin
         mem_data_valid = 1'b0;
         mem_data_out   = 16'($urandom);
      end
      #2;
      model_cycle(exp);
      check_vec($sformatf("cyc%0d", cyc), pack_out(), exp);
      if (mem_en && !mem_wr) begin
         r.data = 16'($urandom);
         r.due  = cyc + int'($urandom_range(lat_min, lat_max));
         mq.push_back(r);
         if (!have_first) begin
            have_first = 1;
            first_rd   = mem_addr;
         end
      end
      if (i_fill_done && ev_i < 0) ev_i = cyc - scn_r;
      if (d_fill_done && ev_d < 0) ev_d = cyc - scn_r;
      if (d_wr_ack && ev_ack < 0) begin
         ev_ack = cyc - scn_r; ack_addr = mem_addr; ack_data = mem_data_in;
      end
      if (i_fill_done) drop_i = 1;
      if (d_fill_done) drop_d = 1;
      if (d_wr_ack)    drop_w = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (drop_i) begin i_miss = 0;   drop_i = 0; end
      if (drop_d) begin d_miss = 0;   drop_d = 0; end
      if (drop_w) begin d_wr_req = 0; drop_w = 0; end
   endtask

   task automatic begin_scn();
      scn_r = cyc; ev_i = -1; ev_d = -1; ev_ack = -1;
      have_first = 0; first_rd = 0; ack_addr = 0; ack_data = 0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300 && (m_active || mq.size() > 0 || i_miss || d_miss || d_wr_req); i++)
         step();
      if (m_active || mq.size() > 0 || i_miss || d_miss || d_wr_req) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no return to idle within 300 cycles (busy=%0b)", name, busy);
         i_miss = 0; d_miss = 0; d_wr_req = 0;
      end
   endtask

   initial begin
      tbl[0] = '{1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4, 16'h1230, 12, -1, -1};
      tbl[1] = '{1, 16'h0100, 1, 16'h2008, 0, 16'h0000, 16'h0000, 4, 16'h2000, 25, 12, -1};
      tbl[2] = '{0, 16'h0000, 1, 16'h4010, 1, 16'h3002, 16'hBEEF, 4, 16'h4010, -1, 14, 1};
      tbl[3] = '{0, 16'h0000, 0, 16'h0000, 1, 16'h0A0A, 16'h1234, 4, 16'h0000, -1, -1, 1};
      tbl[4] = '{1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1230, 9, -1, -1};
      tbl[5] = '{0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 4, 16'hFFF0, -1, 12, -1};
      tbl[6] = '{1, 16'h7FFE, 1, 16'h8001, 1, 16'h5554, 16'h0F0F, 2, 16'h8000, 23, 12, 1};

      // reset held with every request and the memory valid active
      rst_n = 0;
      i_miss = 1; i_miss_addr = 16'h1234;
      d_miss = 1; d_miss_addr = 16'h2008;
      d_wr_req = 1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
      mem_data_valid = 1; mem_data_out = 16'hA5A5;
      repeat (3) @(posedge clk);
      #1;
      check_vec("reset_hold", pack_out(), '0);
      i_miss = 0; d_miss = 0; d_wr_req = 0; mem_data_valid = 0;
      rst_n = 1;
      step();

      foreach (tbl[n]) begin
         lat_min = tbl[n].lat; lat_max = tbl[n].lat;
         begin_scn();
         i_miss = tbl[n].im; i_miss_addr = tbl[n].ia;
         d_miss = tbl[n].dm; d_miss_addr = tbl[n].da;
         d_wr_req = tbl[n].w; d_wr_addr = tbl[n].wa; d_wr_data = tbl[n].wd;
         wait_idle($sformatf("scn%0d", n));
         check_int($sformatf("scn%0d_first_rd_addr", n), int'(first_rd), int'(tbl[n].e_first));
         check_int($sformatf("scn%0d_i_done_cycle", n), ev_i, tbl[n].e_i);
         check_int($sformatf("scn%0d_d_done_cycle", n), ev_d, tbl[n].e_d);
         check_int($sformatf("scn%0d_ack_cycle", n), ev_ack, tbl[n].e_ack);
         step();
      end

      // store rising mid-fill waits for the fill to finish
      lat_min = 4; lat_max = 4;
      begin_scn();
      i_miss = 1; i_miss_addr = 16'h1234;
      for (int i = 0; i < 60 && (i_miss || d_wr_req || m_active || cyc <= scn_r + 3); i++) begin
         if (cyc == scn_r + 3) begin
            d_wr_req = 1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
         end
         step();
      end
      wait_idle("wr_during_fill");
      check_int("wr_mid_i_done_cycle", ev_i, 12);
      check_int("wr_mid_ack_cycle", ev_ack, 14);
      check_int("wr_mid_ack_addr", int'(ack_addr), 16'h3002);
      check_int("wr_mid_ack_data", int'(ack_data), 16'hBEEF);

      // asynchronous reset in cycle 6 of a fill
      begin_scn();
      i_miss = 1; i_miss_addr = 16'h2468;
      while (cyc < scn_r + 6) step();
      #1;
      check_int("pre_reset_busy", int'(busy), 1);
      rst_n = 0;
      i_miss = 0;
      #1;
      check_vec("async_reset_immediate", pack_out(), '0);
      rst_n = 1;
      m_active = 0;
      wait_idle("stale_valids");
      check_int("reset_no_i_done", ev_i, -1);
      begin_scn();
      i_miss = 1; i_miss_addr = 16'h1234;
      wait_idle("fill_after_reset");
      check_int("after_reset_i_done_cycle", ev_i, 12);
      check_int("after_reset_first_rd_addr", int'(first_rd), 16'h1230);

      // random traffic with variable, order-preserving memory latency
      lat_min = 1; lat_max = 6;
      for (int n = 0; n < 1500; n++) begin
         if (!i_miss && $urandom_range(0, 9) == 0) begin
            i_miss = 1; i_miss_addr = 16'($urandom);
         end else if (i_miss && $urandom_range(0, 3) == 0) begin
            i_miss_addr = 16'($urandom);
         end
         if (!d_miss && $urandom_range(0, 9) == 0) begin
            d_miss = 1; d_miss_addr = 16'($urandom);
         end else if (d_miss && $urandom_range(0, 3) == 0) begin
            d_miss_addr = 16'($urandom);
         end
         if (!d_wr_req && $urandom_range(0, 14) == 0) begin
            d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
         end else if (d_wr_req && $urandom_range(0, 3) == 0) begin
            d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
         end
         step();
      end
      wait_idle("random_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
